// File: rtl/key_encoder_8to3.sv
`default_nettype none
// ============================================================================
// key_encoder_8to3 : synchronized, debounced 8-key priority encoder with
//                    press/release strobes and level status flags
// Revision 1.0
// ============================================================================
module key_encoder_8to3 #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       KEY1,
    input  logic       KEY2,
    input  logic       KEY3,
    input  logic       KEY4,
    input  logic       KEY5,
    input  logic       KEY6,
    input  logic       KEY7,
    input  logic       KEY8,
    output logic [2:0] code,
    output logic       any_key,
    output logic       multi_key,
    output logic       key_valid,
    output logic       key_release
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [0:0]       S_IDLE    = 1'b0;
    localparam logic [0:0]       S_PRESSED = 1'b1;

    logic [7:0]       w_keys;
    logic [7:0]       r_sync1;
    logic [7:0]       r_sync2;
    logic [7:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_stable;
    logic [0:0]       r_state;
    logic [2:0]       r_code;
    logic             r_any;
    logic             r_multi;
    logic             r_valid;
    logic             r_release;

    logic [2:0]       w_code;
    logic [3:0]       w_pop;
    logic             w_multi;
    logic             w_commit;

    assign w_keys = {KEY8, KEY7, KEY6, KEY5, KEY4, KEY3, KEY2, KEY1};

    // Lowest-numbered pressed key wins; scan from the top so bit 0 lands last.
    always_comb begin
        w_code = 3'd0;
        w_pop  = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_cand[i]) begin
                w_code = 3'(i);
            end
            w_pop = w_pop + {3'd0, r_cand[i]};
        end
    end

    assign w_multi  = (w_pop >= 4'd2);
    assign w_commit = (r_sync2 == r_cand) && (r_cnt == C_CNT_MAX) && (r_cand != r_stable);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_cand    <= '0;
            r_cnt     <= '0;
            r_stable  <= '0;
            r_state   <= S_IDLE;
            r_code    <= '0;
            r_any     <= 1'b0;
            r_multi   <= 1'b0;
            r_valid   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= w_keys;
            r_sync2   <= r_sync1;
            r_valid   <= 1'b0;
            r_release <= 1'b0;

            if (r_sync2 != r_cand) begin
                r_cand <= r_sync2;
                r_cnt  <= '0;
            end else if (r_cnt < C_CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_commit) begin
                r_stable <= r_cand;
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_PRESSED;
                        r_valid <= 1'b1;
                        r_code  <= w_code;
                        r_any   <= 1'b1;
                        r_multi <= w_multi;
                    end
                    default: begin
                        if (r_cand == 8'd0) begin
                            r_state   <= S_IDLE;
                            r_release <= 1'b1;
                            r_any     <= 1'b0;
                            r_multi   <= 1'b0;
                        end else begin
                            // Only a change of the winning key counts as a new press.
                            if (w_code != r_code) begin
                                r_valid <= 1'b1;
                                r_code  <= w_code;
                            end
                            r_multi <= w_multi;
                        end
                    end
                endcase
            end
        end
    end

    assign code        = r_code;
    assign any_key     = r_any;
    assign multi_key   = r_multi;
    assign key_valid   = r_valid;
    assign key_release = r_release;

endmodule
`default_nettype wire

// File: tb/tb_key_encoder_8to3.sv
`default_nettype none
// Bench for key_encoder_8to3: directed key sequences with an event scoreboard.
module tb_key_encoder_8to3;

    localparam int DB = 4;
    localparam int LAT = DB + 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] keys;
    logic [2:0] code;
    logic       any_key, multi_key, key_valid, key_release;

    typedef struct {
        bit       rel;
        bit [2:0] code;
        bit       any;
        bit       multi;
        int       due;
    } ev_t;

    ev_t q[$];
    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;

    key_encoder_8to3 #(.DEBOUNCE_CYCLES(DB), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .KEY1(keys[0]), .KEY2(keys[1]), .KEY3(keys[2]), .KEY4(keys[3]),
        .KEY5(keys[4]), .KEY6(keys[5]), .KEY7(keys[6]), .KEY8(keys[7]),
        .code(code), .any_key(any_key), .multi_key(multi_key),
        .key_valid(key_valid), .key_release(key_release)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] v);
        @(negedge clk);
        keys = v;
    endtask

    task automatic push(input bit rel, input bit [2:0] c, input bit a, input bit m);
        ev_t e;
        e.rel = rel; e.code = c; e.any = a; e.multi = m; e.due = cyc + LAT;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: every strobe must match the oldest expected event, on time.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (key_valid || key_release) begin
                ev_t e;
                check("strobe_exclusive", int'(key_valid & key_release), 0);
                check("strobe_expected", int'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("strobe_cycle", cyc, e.due);
                    check("strobe_is_release", int'(key_release), int'(e.rel));
                    check("strobe_code", int'(code), int'(e.code));
                    check("strobe_any_key", int'(any_key), int'(e.any));
                    check("strobe_multi_key", int'(multi_key), int'(e.multi));
                end
            end else if (q.size() != 0 && q[0].due <= cyc) begin
                check("strobe_missing", int'(key_valid | key_release), 1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        keys  = 8'd0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        check("rst_code", int'(code), 0);
        check("rst_any_key", int'(any_key), 0);
        check("rst_multi_key", int'(multi_key), 0);
        check("rst_key_valid", int'(key_valid), 0);
        check("rst_key_release", int'(key_release), 0);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(3);

        // Single key press and release; code must hold after release
        drive(8'h04); push(0, 3'd2, 1, 0); wait_cyc(10);
        check("k3_level_code", int'(code), 2);
        check("k3_level_any", int'(any_key), 1);
        drive(8'h00); push(1, 3'd2, 0, 0); wait_cyc(10);
        check("k3_hold_code", int'(code), 2);
        check("k3_idle_any", int'(any_key), 0);

        // Bounce on KEY5 restarts the window each time
        drive(8'h10); wait_cyc(1);
        drive(8'h00); wait_cyc(1);
        drive(8'h10); push(0, 3'd4, 1, 0); wait_cyc(10);
        drive(8'h00); push(1, 3'd4, 0, 0); wait_cyc(10);

        // Rollover: KEY6, then KEY2 added, then KEY8 added silently
        drive(8'h20); push(0, 3'd5, 1, 0); wait_cyc(10);
        drive(8'h22); push(0, 3'd1, 1, 1); wait_cyc(10);
        drive(8'hA2); wait_cyc(10);
        check("rollover_code", int'(code), 1);
        check("rollover_multi", int'(multi_key), 1);
        drive(8'h00); push(1, 3'd1, 0, 0); wait_cyc(10);
        check("rollover_multi_cleared", int'(multi_key), 0);

        // Simultaneous KEY1 + KEY8
        drive(8'h81); push(0, 3'd0, 1, 1); wait_cyc(10);
        drive(8'h00); push(1, 3'd0, 0, 0); wait_cyc(10);

        // Reset in the middle of a debounce window while a key is committed
        drive(8'h20); push(0, 3'd5, 1, 0); wait_cyc(10);
        drive(8'h08); wait_cyc(3);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("midrst_code", int'(code), 0);
        check("midrst_any", int'(any_key), 0);
        wait_cyc(3);
        rst_n = 1'b1;
        push(0, 3'd3, 1, 0); wait_cyc(10);
        drive(8'h00); push(1, 3'd3, 0, 0); wait_cyc(10);

        // Sweep every key individually
        for (int k = 0; k < 8; k++) begin
            drive(8'(1 << k)); push(0, 3'(k), 1, 0); wait_cyc(10);
            drive(8'h00); push(1, 3'(k), 0, 0); wait_cyc(10);
        end

        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_encoder_8to3.md
Name: key_encoder_8to3

Overview:
- Input-side counterpart of the 3-to-8 COM line decoder: takes eight raw, asynchronous push-button lines KEY1..KEY8 and returns a debounced, priority-encoded 3-bit key code.
- Code mapping is the inverse of the COM decode: KEY1 -> 3'b000 ... KEY8 -> 3'b111.
- Sits between the board buttons and the control FSM. Provides a one-cycle press strobe, a one-cycle release strobe and level status flags.

Parameters:
- DEBOUNCE_CYCLES, 20000, consecutive clock edges the synchronized key vector must hold unchanged before it is accepted. Legal range 1..65535.
- CNT_W, 16, debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- KEY1..KEY8  input  1 each  raw button lines, active-high, asynchronous to clk
- code  output  3  priority-encoded index of lowest-numbered pressed key (KEY1=0 ... KEY8=7)
- any_key  output  1  high while debounced vector is nonzero
- multi_key  output  1  high while two or more keys are pressed in the debounced vector
- key_valid  output  1  one-cycle strobe: new code accepted
- key_release  output  1  one-cycle strobe: all keys released

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all registers clear on rst_n low, regardless of clk. This covers sync flops, candidate, counter, stable vector, FSM (IDLE) and all outputs. code=0, any_key=0, multi_key=0, key_valid=0, key_release=0.
- Synchronizer: each KEY passes through two flops, giving s2[7:0] (bit0 = KEY1).
- Debounce:
  - Registers cand[7:0] and cnt.
  - Each edge, if s2 != cand: cand<=s2, cnt<=0.
  - Otherwise, if cnt < DEBOUNCE_CYCLES-1: cnt<=cnt+1, saturating at DEBOUNCE_CYCLES-1.
  - Commit condition: s2==cand, cnt==DEBOUNCE_CYCLES-1 and cand != stable. On that edge, stable<=cand.
- Latency: a clean raw change is reflected on the outputs after exactly DEBOUNCE_CYCLES+3 rising edges. Any toggle inside the window restarts the count, and no commit occurs.
- Registered outputs: code, any_key, multi_key, key_valid and key_release all update on the commit edge, computed from cand.
  - code = index of lowest set bit.
  - multi_key = popcount>=2.
- FSM states and transitions:
  - IDLE (stable==0):
    - Commit of a nonzero vector -> PRESSED. key_valid=1 for the following cycle; code loaded.
  - PRESSED (stable!=0):
    - Commit of a nonzero vector whose priority code differs from current code -> stay PRESSED. code updated, key_valid pulses (rollover).
    - Commit of a nonzero vector with the same priority code (a higher key added or removed) -> no key_valid. code unchanged; multi_key updated.
    - Commit of zero -> IDLE. key_release pulses; any_key=0; multi_key=0.
- code holds its last value while IDLE. It is only 0 after reset or after KEY1 is pressed.
- key_valid and key_release are never high in the same cycle. Each is high for exactly one cycle per commit.
- Simultaneous presses: keys that become stable together commit as one vector. The result is one key_valid with the lowest index as code, and multi_key=1.
- Reset mid-operation: a key held across reset release is seen as a fresh press. key_valid fires DEBOUNCE_CYCLES+3 edges after rst_n rises, not counting the asynchronous deassert edge.
- DEBOUNCE_CYCLES=1: commit occurs on the edge after cand captures, so latency is 4 edges.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset → all outputs 0. Then hold KEY3=1 → key_valid high one cycle at edge 7 after the change, with code=3'b010, any_key=1, multi_key=0. Release KEY3 → key_release one cycle after 7 edges, any_key=0, code stays 3'b010.
- Bounce: KEY5 toggles 1,0,1 every 2 cycles, then holds 1 → no key_valid during toggling. A single key_valid fires 7 edges after the final rise, with code=3'b100.
- Rollover: hold KEY6 (code 5), then add KEY2 → second key_valid with code=3'b001 and multi_key=1. Then add KEY8 → no key_valid, code stays 3'b001.
- Simultaneous: KEY1 and KEY8 rise in the same cycle → exactly one key_valid, code=3'b000, multi_key=1. Release both → one key_release.
- Reset mid-press: hold KEY4, assert rst_n low for 3 cycles mid-window → outputs cleared immediately. After rst_n rises with KEY4 still held → key_valid 7 edges later, code=3'b011.
- Sweep KEY1..KEY8 individually (press/release each) → code equals 0..7 respectively, with one key_valid and one key_release per key.
